// File: rtl/gpu_palette_pkg.sv
// Shared palette-stage types: index/RGB widths
// and the scheduler state encoding.
package gpu_palette_pkg;

  localparam int PAL_IDX_W = 8;
  localparam int RGB_W     = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/palette_ram_sp.sv
// 256x24 synchronous single-port palette RAM.
// Read-first: rdata returns the pre-write word.
module palette_ram_sp
  import gpu_palette_pkg::*;
(
  input  logic                 clk_pipe,
  input  logic                 we,
  input  logic [PAL_IDX_W-1:0] addr,
  input  logic [RGB_W-1:0]     wdata,
  output logic [RGB_W-1:0]     rdata
);

  logic [RGB_W-1:0] mem [0:(1<<PAL_IDX_W)-1];

  always_ff @(posedge clk_pipe) begin
    rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/palette_lookup_scheduler.sv
// Palette stage: index->RGB lookup into the CDC FIFO,
// sharing the RAM port with CPU palette writes.
module palette_lookup_scheduler
  import gpu_palette_pkg::*;
#(
  parameter int FIFO_AW      = 8,
  parameter int FIFO_CAP     = 255,
  parameter int MARGIN       = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk_pipe,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pix_valid,
  input  logic [PAL_IDX_W-1:0] pix_index,
  output logic                 pix_ready,
  input  logic                 cfg_valid,
  input  logic [PAL_IDX_W-1:0] cfg_addr,
  input  logic [RGB_W-1:0]     cfg_data,
  output logic                 cfg_ready,
  input  logic [FIFO_AW-1:0]   fifo_size,
  output logic                 fifo_writeEn,
  output logic [RGB_W-1:0]     fifo_dataIn,
  output logic                 busy,
  output logic [15:0]          pix_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [FIFO_AW:0] LIMIT =
    (FIFO_AW+1)'(FIFO_CAP - MARGIN);

  state_t               state;
  state_t               state_nxt;
  logic                 inflight;
  logic [SW-1:0]        starve;
  logic                 starved;
  logic                 credit_ok;
  logic                 pix_fire;
  logic                 cfg_fire;
  logic [PAL_IDX_W-1:0] ram_addr;
  logic [RGB_W-1:0]     rdata;
  logic [RGB_W-1:0]     hold;

  // Widened so occupancy plus the in-flight word never wraps.
  assign credit_ok =
    ({1'b0, fifo_size} + {{FIFO_AW{1'b0}}, inflight}) < LIMIT;

  assign starved = starve >= SW'(STARVE_LIMIT);

  // Readies are forced low while reset is held.
  always_comb begin
    pix_ready = 1'b0;
    cfg_ready = 1'b0;
    if (reset) begin
      unique case (1'b1)
        (state != RUN) || starved: begin
          cfg_ready = 1'b1;
        end
        default: begin
          pix_ready = credit_ok;
          cfg_ready = !(pix_valid && credit_ok);
        end
      endcase
    end
  end

  assign pix_fire = pix_valid && pix_ready;
  assign cfg_fire = cfg_valid && cfg_ready;
  assign ram_addr = cfg_fire ? cfg_addr : pix_index;

  palette_ram_sp u_ram (
    .clk_pipe (clk_pipe),
    .we       (cfg_fire),
    .addr     (ram_addr),
    .wdata    (cfg_data),
    .rdata    (rdata)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable)    state_nxt = RUN;
      RUN:     if (!enable)   state_nxt = DRAIN;
      DRAIN:   if (!inflight) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pipe or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (cfg_fire) begin
      starve <= '0;
    end else if (cfg_valid && !(&starve)) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk_pipe or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      hold      <= '0;
      pix_count <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= pix_fire;
      if (inflight) hold <= rdata;
      if (state == IDLE && enable) begin
        pix_count <= '0;
      end else if (inflight) begin
        pix_count <= pix_count + 16'd1;
      end
    end
  end

  // RAM output wanders with the address, so idle cycles show the held word.
  assign fifo_writeEn = inflight;
  assign fifo_dataIn  = inflight ? rdata : hold;
  assign busy         = state != IDLE;

endmodule

// File: tb/tb_palette_lookup_scheduler.sv
// Directed bench for palette_lookup_scheduler with a
// cycle-level reference model and literal spot checks.
module tb_palette_lookup_scheduler;

  logic        clk_pipe = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_index = '0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [23:0] cfg_data = '0;
  logic [7:0]  fifo_size = '0;
  logic        pix_ready;
  logic        cfg_ready;
  logic        fifo_writeEn;
  logic [23:0] fifo_dataIn;
  logic        busy;
  logic [15:0] pix_count;

  int vectors = 0;
  int errors = 0;

  palette_lookup_scheduler dut (
    .clk_pipe     (clk_pipe),
    .reset        (reset),
    .enable       (enable),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pix_ready    (pix_ready),
    .cfg_valid    (cfg_valid),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .fifo_size    (fifo_size),
    .fifo_writeEn (fifo_writeEn),
    .fifo_dataIn  (fifo_dataIn),
    .busy         (busy),
    .pix_count    (pix_count)
  );

  always #5 clk_pipe = ~clk_pipe;

  task automatic cmp(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=streaming 2=draining
  int          m_mode = 0;
  int          m_starve = 0;
  bit          m_infl = 0;
  int          m_cnt = 0;
  logic [23:0] m_mem [256];
  bit          m_known [256];
  logic [23:0] m_pend = '0;
  bit          m_pend_ok = 0;
  logic [23:0] m_last = '0;
  bit          m_last_ok = 1;

  function automatic void m_grant(output bit pr, output bit cr);
    bit room;
    room = (int'(fifo_size) + (m_infl ? 1 : 0)) < (255 - 4);
    pr = 0;
    cr = 0;
    if (reset) begin
      if (m_mode != 1 || m_starve >= 16) cr = 1;
      else begin
        pr = room;
        cr = !(pix_valid && room);
      end
    end
  endfunction

  always @(posedge clk_pipe or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_starve = 0; m_infl = 0; m_cnt = 0;
      m_last = '0; m_last_ok = 1;
    end else begin
      bit pr, cr, was_infl;
      m_grant(pr, cr);
      was_infl = m_infl;
      if (m_infl) begin
        m_last = m_pend; m_last_ok = m_pend_ok;
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_infl = pix_valid && pr;
      if (m_infl) begin
        m_pend = m_mem[pix_index]; m_pend_ok = m_known[pix_index];
      end
      if (cfg_valid && cr) begin
        m_mem[cfg_addr] = cfg_data; m_known[cfg_addr] = 1; m_starve = 0;
      end else if (cfg_valid) begin
        m_starve = m_starve + 1;
      end
      if (m_mode == 0 && enable) begin m_mode = 1; m_cnt = 0; end
      else if (m_mode == 1 && !enable) m_mode = 2;
      else if (m_mode == 2 && !was_infl) m_mode = 0;
    end
  end

  always @(negedge clk_pipe) begin
    bit pr, cr;
    m_grant(pr, cr);
    cmp("pix_ready", 32'(pix_ready), 32'(pr));
    cmp("cfg_ready", 32'(cfg_ready), 32'(cr));
    cmp("fifo_writeEn", 32'(fifo_writeEn), 32'(m_infl));
    cmp("busy", 32'(busy), 32'(m_mode != 0));
    cmp("pix_count", 32'(pix_count), 32'(m_cnt));
    if (m_infl ? m_pend_ok : m_last_ok)
      cmp("fifo_dataIn", 32'(fifo_dataIn), 32'(m_infl ? m_pend : m_last));
  end

  task automatic step();
    @(posedge clk_pipe);
    #1;
  endtask

  initial begin
    int g;
    bit pr_g;
    #22 reset = 1'b1;
    step();
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_count", 32'(pix_count), 0);
    // Preload palette in IDLE
    cfg_valid = 1; cfg_addr = 8'd5; cfg_data = 24'h123456;
    step();
    cfg_addr = 8'd9; cfg_data = 24'h010203;
    step();
    cfg_valid = 0; enable = 1;
    step();
    // Test 1: basic lookup
    pix_valid = 1; pix_index = 8'd5; #1;
    cmp("t1_ready", 32'(pix_ready), 1);
    step();
    pix_valid = 0; #1;
    cmp("t1_we", 32'(fifo_writeEn), 1);
    cmp("t1_data", 32'(fifo_dataIn), 32'h123456);
    step();
    cmp("t1_we_off", 32'(fifo_writeEn), 0);
    cmp("t1_hold", 32'(fifo_dataIn), 32'h123456);
    // Test 4: cfg/pixel ordering on idx 9
    pix_valid = 1; pix_index = 8'd9;
    cfg_valid = 1; cfg_addr = 8'd9; cfg_data = 24'hABCDEF; #1;
    cmp("t4_cfg_blocked", 32'(cfg_ready), 0);
    step();
    pix_valid = 0; #1;
    cmp("t4_old", 32'(fifo_dataIn), 32'h010203);
    step();
    cfg_valid = 0; pix_valid = 1; pix_index = 8'd9;
    step();
    pix_valid = 0; #1;
    cmp("t4_new", 32'(fifo_dataIn), 32'hABCDEF);
    step();
    // Test 2: FIFO credit throttle
    fifo_size = 8'd251; pix_valid = 1; pix_index = 8'd5; #1;
    cmp("t2_full", 32'(pix_ready), 0);
    step(); step(); step();
    fifo_size = 8'd250; #1;
    cmp("t2_250_idle", 32'(pix_ready), 1);
    step();
    cmp("t2_250_infl", 32'(pix_ready), 0);
    fifo_size = 8'd200;
    step(); step(); step(); step();
    pix_valid = 0; fifo_size = 8'd0;
    step(); step();
    // Test 3: starvation preemption
    pix_valid = 1; pix_index = 8'd5;
    cfg_valid = 1; cfg_addr = 8'd20; cfg_data = 24'h00AA55;
    g = 0; pr_g = 1;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (cfg_ready) begin
        g = i; pr_g = pix_ready;
        step();
        break;
      end
      step();
    end
    cmp("t3_grant_cycle", 32'(g), 17);
    cmp("t3_bubble", 32'(pr_g), 0);
    cfg_valid = 0;
    step(); step();
    // Test 5: drain with pixel in flight
    enable = 0;
    step();
    pix_valid = 0; #1;
    cmp("t5_we", 32'(fifo_writeEn), 1);
    cmp("t5_busy1", 32'(busy), 1);
    step();
    cmp("t5_we_off", 32'(fifo_writeEn), 0);
    cmp("t5_busy2", 32'(busy), 1);
    step();
    cmp("t5_idle", 32'(busy), 0);
    enable = 1;
    step();
    cmp("t5_cnt_clr", 32'(pix_count), 0);
    pix_valid = 1; pix_index = 8'd5;
    step();
    pix_valid = 0;
    step();
    cmp("t5_cnt_one", 32'(pix_count), 1);
    // Test 6: reset with write in flight
    pix_valid = 1; pix_index = 8'd5;
    step();
    pix_valid = 0;
    #1 reset = 0;
    #1;
    cmp("t6_we", 32'(fifo_writeEn), 0);
    cmp("t6_data", 32'(fifo_dataIn), 0);
    cmp("t6_busy", 32'(busy), 0);
    cmp("t6_cnt", 32'(pix_count), 0);
    cmp("t6_pr", 32'(pix_ready), 0);
    cmp("t6_cr", 32'(cfg_ready), 0);
    enable = 0;
    @(posedge clk_pipe);
    @(posedge clk_pipe);
    #3 reset = 1;
    step();
    enable = 1;
    step();
    pix_valid = 1; pix_index = 8'd9;
    step();
    pix_valid = 0; #1;
    cmp("t6_retained", 32'(fifo_dataIn), 32'hABCDEF);
    step();
    enable = 0;
    step(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
